extremum_tracker: RTL and testbench

EXTREMUM_TRACKER -- requirements
Module: extremum_tracker

---
 rtl/extremum_pkg.sv | 21 ++
 rtl/eight_comparator_BCS.sv | 22 ++
 rtl/extremum_tracker.sv | 100 ++++++++++
 tb/tb_extremum_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/extremum_pkg.sv
// Shared types and constants for the windowed min/max tracker.
package extremum_pkg;

   localparam int EXT_DATA_W = 8;   // sample width (only 8 supported)
   localparam int EXT_WINDOW = 8;   // default samples per window

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Registered window result; values keep MSB at bit 0 like the ports.
   typedef struct packed {
      logic [0:EXT_DATA_W-1] max_val;
      logic [0:EXT_DATA_W-1] min_val;
      logic [7:0]            max_idx;
      logic [7:0]            min_idx;
   } result_t;

endpackage

// File: rtl/eight_comparator_BCS.sv
// Unsigned 8-bit magnitude comparator, MSB at bit 0.
// e: a == b, l: a < b.
module eight_comparator_BCS (
   input  logic [0:7] a,
   input  logic [0:7] b,
   output logic       e,
   output logic       l
);

   // Scan from the MSB; the first differing bit decides the ordering.
   always_comb begin
      e = 1'b1;
      l = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (e && (a[i] != b[i])) begin
            l = b[i];
            e = 1'b0;
         end
      end
   end

endmodule

// File: rtl/extremum_tracker.sv
// Tracks max/min value and index of a window of WINDOW unsigned samples.
module extremum_tracker
   import extremum_pkg::*;
#(
   parameter int WINDOW = EXT_WINDOW,
   parameter int DATA_W = EXT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [0:DATA_W-1] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [0:DATA_W-1] max_val,
   output logic [0:DATA_W-1] min_val,
   output logic [7:0]        max_idx,
   output logic [7:0]        min_idx
);

   localparam logic [7:0] LAST = 8'(WINDOW - 1);

   state_t     state, state_n;
   logic [7:0] cnt;
   result_t    res;
   logic       max_e, max_l, min_e, min_l;
   logic       accept;

   // start always wins over a sample presented in the same cycle
   assign accept = (state == ACCUM) && in_valid && !start;

   eight_comparator_BCS u_cmp_max (.a(in_data), .b(res.max_val), .e(max_e), .l(max_l));
   eight_comparator_BCS u_cmp_min (.a(in_data), .b(res.min_val), .e(min_e), .l(min_l));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state and state-decoded status outputs
   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept && (cnt == LAST)) state_n = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_n = ACCUM;
         end
         default: state_n = IDLE;
      endcase
   end

   // Sample counter and extremum registers; values survive a restart
   // until the first sample of the new window overwrites them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         res <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= cnt + 8'd1;
         if (cnt == 8'd0) begin
            res.max_val <= in_data;
            res.min_val <= in_data;
            res.max_idx <= 8'd0;
            res.min_idx <= 8'd0;
         end else begin
            // strictly greater / strictly less, so ties keep the earlier index
            if (!max_e && !max_l) begin
               res.max_val <= in_data;
               res.max_idx <= cnt;
            end
            // l already excludes equality; e is folded in for clarity
            if (min_l && !min_e) begin
               res.min_val <= in_data;
               res.min_idx <= cnt;
            end
         end
      end
   end

   assign max_val = res.max_val;
   assign min_val = res.min_val;
   assign max_idx = res.max_idx;
   assign min_idx = res.min_idx;

endmodule

// File: tb/tb_extremum_tracker.sv
// Self-checking bench: model results are queued as each window is driven
// and popped/compared when the tracker signals done.
module tb_extremum_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [0:7] in_data = '0;
   logic       in_ready, busy, done;
   logic [0:7] max_val, min_val;
   logic [7:0] max_idx, min_idx;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] mx;
      logic [7:0] mn;
      logic [7:0] mxi;
      logic [7:0] mni;
   } exp_t;

   exp_t       sb[$];
   exp_t       last_exp;
   logic [7:0] win[8];

   extremum_tracker #(.WINDOW(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .busy(busy), .done(done),
      .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Model the window, queue the expectation, drive the 8 samples, then
   // check done one cycle after the last sample and compare the result.
   task automatic drive_window(input bit do_start, input string name);
      exp_t e;
      exp_t got;
      e.mx = win[0]; e.mn = win[0]; e.mxi = 0; e.mni = 0;
      for (int i = 1; i < 8; i++) begin
         if (win[i] > e.mx) begin e.mx = win[i]; e.mxi = 8'(i); end
         if (win[i] < e.mn) begin e.mn = win[i]; e.mni = 8'(i); end
      end
      sb.push_back(e);
      if (do_start) begin
         @(negedge clk); start = 1'b1; in_valid = 1'b0;
         @(negedge clk); start = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = win[i];
         @(negedge clk);
      end
      in_valid = 1'b0; in_data = '0;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s_done: got %b want 1", name, done);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s_sb: scoreboard empty at done", name);
      end else begin
         got.mx = max_val; got.mn = min_val; got.mxi = max_idx; got.mni = min_idx;
         e = sb.pop_front();
         last_exp = e;
         if (got !== e) begin
            failures++;
            $display("FAIL %s_result: got max=%0d@%0d min=%0d@%0d want max=%0d@%0d min=%0d@%0d",
                     name, got.mx, got.mxi, got.mn, got.mni, e.mx, e.mxi, e.mn, e.mni);
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({in_ready, busy, done, max_val, min_val, max_idx, min_idx} !== '0) begin
         failures++;
         $display("FAIL %s: got rdy=%b busy=%b done=%b max=%0d@%0d min=%0d@%0d want all 0",
                  name, in_ready, busy, done, max_val, max_idx, min_val, min_idx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset_hold");
      rst = 1'b0;
      // samples without start are ignored in IDLE
      in_valid = 1'b1; in_data = 8'hAA;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check_zero("idle_ignore");
   endtask

   task automatic test_basic();
      win = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd200, 8'd200, 8'd0, 8'd7};
      drive_window(1'b1, "basic");
   endtask

   task automatic test_ties();
      win = '{default: 8'h55};
      drive_window(1'b1, "ties");
   endtask

   task automatic test_msb();
      win = '{8'h00, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      drive_window(1'b1, "msb");
   endtask

   task automatic test_random();
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 8; i++) win[i] = 8'($urandom_range(0, 255));
         drive_window(1'b1, "random");
      end
   endtask

   task automatic test_restart();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(10 + i);
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL restart_busy: got busy=%b done=%b want busy=1 done=0", busy, done);
      end
      start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      @(negedge clk);
      start = 1'b0;
      win = '{8'd50, 8'd20, 8'd90, 8'd30, 8'd90, 8'd5, 8'd60, 8'd5};
      drive_window(1'b0, "restart");
   endtask

   task automatic test_async_reset();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'(100 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (max_val !== 8'd104) begin
         failures++;
         $display("FAIL pre_reset_max: got %0d want 104", max_val);
      end
      #2 rst = 1'b1;
      #1 check_zero("async_reset");
      #1 rst = 1'b0;
      in_valid = 1'b1; in_data = 8'hFF;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check_zero("post_reset_idle");
   endtask

   task automatic test_done_hold();
      win = '{8'd4, 8'd8, 8'd2, 8'd6, 8'd1, 8'd9, 8'd3, 8'd7};
      drive_window(1'b1, "hold_window");
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; in_data = 8'hFF;
         @(negedge clk);
         checks++;
         if (done !== 1'b1 || max_val !== last_exp.mx || max_idx !== last_exp.mxi ||
             min_val !== last_exp.mn || min_idx !== last_exp.mni || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_hold: got done=%b rdy=%b max=%0d@%0d min=%0d@%0d want done=1 rdy=0 max=%0d@%0d min=%0d@%0d",
                     done, in_ready, max_val, max_idx, min_val, min_idx,
                     last_exp.mx, last_exp.mxi, last_exp.mn, last_exp.mni);
         end
      end
      in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL start_from_done: got done=%b busy=%b want done=0 busy=1", done, busy);
      end
      // back-to-back window straight out of DONE
      win = '{8'd255, 8'd0, 8'd128, 8'd127, 8'd1, 8'd254, 8'd0, 8'd255};
      drive_window(1'b0, "back_to_back");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_msb();
      test_random();
      test_restart();
      test_async_reset();
      test_done_hold();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
